// File: rtl/mem_ctrl_if.sv
// SRAM-style access bus between a master and mem_ctrl: address, enables, write data and registered read data.
interface mem_ctrl_if;
  logic [15:0] addr;
  logic        ce;
  logic        csb;
  logic        web;
  logic        oeb;
  logic [7:0]  idata;
  logic [7:0]  odata;

  modport master (output addr, ce, csb, web, oeb, idata, input odata);
  modport slave  (input addr, ce, csb, web, oeb, idata, output odata);
endinterface

// File: rtl/mem_ctrl.sv
// Byte-wide 64 KiB single-port memory controller with SRAM-style controls and a registered read port.
module mem_ctrl (
  input  logic      clk,
  input  logic      rstn,
  mem_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WR, RD} op_t;

  op_t        op_next;
  logic [7:0] mem [0:65535];
  logic [7:0] odata_reg;

  // Per-edge decode with no carried state; a write takes priority over OEB.
  always_comb begin
    op_next = IDLE;
    if (bus.ce && !bus.csb) begin
      if (!bus.web)
        op_next = WR;
      else if (!bus.oeb)
        op_next = RD;
    end
  end

  // Storage is never cleared; reset only suppresses an access on that edge.
  always_ff @(posedge clk) begin
    if (rstn && (op_next == WR))
      mem[bus.addr] <= bus.idata;
  end

  always_ff @(posedge clk) begin
    if (!rstn)
      odata_reg <= 8'h00;
    else if (op_next == RD)
      odata_reg <= mem[bus.addr];
  end

  assign bus.odata = odata_reg;
endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed vector table, random burst, and hand-written reset/boundary sequences.
module tb_mem_ctrl;
  logic clk = 1'b0;
  logic rstn;
  mem_ctrl_if bus ();

  mem_ctrl dut (.clk(clk), .rstn(rstn), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rstn;
    logic        ce;
    logic        csb;
    logic        web;
    logic        oeb;
    logic [15:0] addr;
    logic [7:0]  idata;
    logic [7:0]  exp;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } sb_t;

  sb_t        sb_q[$];
  vec_t       vecs[11];
  logic [7:0] wdata[10];
  logic [7:0] last;
  int         tests  = 0;
  int         errors = 0;

  // Drive on the falling edge, queue the expectation, sample 1 ns after the rising edge.
  task automatic step(input string name, input logic r, input logic ce, input logic csb,
                      input logic web, input logic oeb, input logic [15:0] addr,
                      input logic [7:0] idata, input logic [7:0] exp);
    sb_t e;
    sb_t got;
    @(negedge clk);
    rstn      = r;
    bus.ce    = ce;
    bus.csb   = csb;
    bus.web   = web;
    bus.oeb   = oeb;
    bus.addr  = addr;
    bus.idata = idata;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    tests++;
    if (bus.odata !== got.exp) begin
      errors++;
      $display("FAIL %s: odata=%h required=%h", got.name, bus.odata, got.exp);
    end else begin
      $display("ok   %s: odata=%h", got.name, bus.odata);
    end
  endtask

  task automatic wr(input string name, input logic [15:0] a, input logic [7:0] d, input logic [7:0] exp);
    step(name, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, a, d, exp);
  endtask

  task automatic rd(input string name, input logic [15:0] a, input logic [7:0] exp);
    step(name, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, a, 8'h00, exp);
  endtask

  task automatic idle(input string name, input logic [7:0] exp);
    step(name, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 8'h00, exp);
  endtask

  initial begin
    vecs[0]  = '{"anchor_rd_0010",  1, 1, 0, 1, 0, 16'h0010, 8'h00, 8'h11};
    vecs[1]  = '{"wr_0100_55",      1, 1, 0, 0, 1, 16'h0100, 8'h55, 8'h11};
    vecs[2]  = '{"wr_ce0_ignored",  1, 0, 0, 0, 1, 16'h0100, 8'hFF, 8'h11};
    vecs[3]  = '{"wr_csb1_ignored", 1, 1, 1, 0, 1, 16'h0100, 8'hFF, 8'h11};
    vecs[4]  = '{"rd_0100",         1, 1, 0, 1, 0, 16'h0100, 8'h00, 8'h55};
    vecs[5]  = '{"rd_ce0_ignored",  1, 0, 0, 1, 0, 16'h0010, 8'h00, 8'h55};
    vecs[6]  = '{"wr_prio_oeb0",    1, 1, 0, 0, 0, 16'h0200, 8'h3C, 8'h55};
    vecs[7]  = '{"rd_0200",         1, 1, 0, 1, 0, 16'h0200, 8'h00, 8'h3C};
    vecs[8]  = '{"nop_selected",    1, 1, 0, 1, 1, 16'h0010, 8'hEE, 8'h3C};
    vecs[9]  = '{"wr_ffff_81",      1, 1, 0, 0, 1, 16'hFFFF, 8'h81, 8'h3C};
    vecs[10] = '{"rd_ffff_b2b",     1, 1, 0, 1, 0, 16'hFFFF, 8'h00, 8'h81};

    rstn = 1'b0;
    bus.ce = 1'b0; bus.csb = 1'b1; bus.web = 1'b1; bus.oeb = 1'b1;
    bus.addr = 16'h0000; bus.idata = 8'h00;

    // Reset, seed 0x0010, then hold reset with a pending write of 0xAA.
    step("init_reset", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 8'h00, 8'h00);
    wr("seed_0010", 16'h0010, 8'h11, 8'h00);
    for (int i = 0; i < 4; i++)
      step($sformatf("reset_wr_dropped_%0d", i), 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0010, 8'hAA, 8'h00);
    rd("rd_0010_after_reset", 16'h0010, 8'h11);
    idle("idle_hold_11", 8'h11);
    last = 8'h11;

    for (int i = 0; i < 10; i++) begin
      wdata[i] = 8'($urandom_range(0, 255));
      wr($sformatf("burst_wr_%0d", i), 16'(i), wdata[i], last);
      idle($sformatf("burst_wr_idle_%0d", i), last);
    end
    for (int i = 0; i < 10; i++) begin
      rd($sformatf("burst_rd_%0d", i), 16'(i), wdata[i]);
      idle($sformatf("burst_rd_idle_%0d", i), wdata[i]);
    end

    for (int i = 0; i < 11; i++)
      step(vecs[i].name, vecs[i].rstn, vecs[i].ce, vecs[i].csb, vecs[i].web,
           vecs[i].oeb, vecs[i].addr, vecs[i].idata, vecs[i].exp);

    rd("rd_0000_untouched", 16'h0000, wdata[0]);
    rd("rd_ffff_again", 16'hFFFF, 8'h81);
    // Reset sampled together with a read: read dropped, output cleared.
    step("reset_rd_dropped", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFF, 8'h00, 8'h00);
    idle("idle_after_reset", 8'h00);
    rd("rd_ffff_retained", 16'hFFFF, 8'h81);

    wr("wr_1234_c3", 16'h1234, 8'hC3, 8'h81);
    rd("rd_1234_b2b", 16'h1234, 8'hC3);
    step("reset_wr_dropped_1234", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1234, 8'h00, 8'h00);
    rd("rd_1234_retained", 16'h1234, 8'hC3);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
